// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding imem request feeding a DEPTH-entry {word, pc} buffer for decode.
// Latency: id_valid one cycle after imem_valid when empty; requests stall while the buffer plus the in-flight slot is full.
module instr_fetch #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [15:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [3:0]        opcode,
  output logic [3:0]        rd,
  output logic [3:0]        rs,
  output logic [3:0]        imm,
  output logic [ADDR_W-1:0] id_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [15:0]       word;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  entry_t             fifo_q [DEPTH];
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  req_pc_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               outs_q;
  logic               drop_q;

  logic               pop;
  logic               rsp;
  logic               push;
  logic [CNT_W-1:0]   count_after_pop;
  entry_t             head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign id_valid        = (count_q != '0);
  assign pop             = id_valid & id_ready;
  assign rsp             = imem_valid & outs_q;
  assign push            = rsp & ~drop_q & ~redirect;
  assign count_after_pop = count_q - CNT_W'(pop);

  // Gated by rst_n so the request is low for the whole reset, not just after the first edge.
  assign imem_req  = rst_n & ~redirect & ~outs_q & (count_after_pop < CNT_W'(DEPTH));
  assign imem_addr = pc_q;

  assign head   = fifo_q[rd_ptr_q];
  assign opcode = id_valid ? head.word[15:12] : 4'h0;
  assign rd     = id_valid ? head.word[11:8]  : 4'h0;
  assign rs     = id_valid ? head.word[7:4]   : 4'h0;
  assign imm    = id_valid ? head.word[3:0]   : 4'h0;
  assign id_pc  = id_valid ? head.pc          : '0;

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{word: imem_rdata, pc: req_pc_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      req_pc_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      outs_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
        pc_q     <= redirect_pc;
      end else begin
        if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        if (imem_req) begin
          pc_q     <= pc_q + ADDR_W'(1);
          req_pc_q <= pc_q;
        end
      end

      if (rsp)           outs_q <= 1'b0;
      else if (imem_req) outs_q <= 1'b1;

      // A response in flight across a redirect belongs to the old stream and must be discarded.
      if (rsp)                     drop_q <= 1'b0;
      else if (redirect && outs_q) drop_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a vector table for streaming/stall, then hand sequences for redirect, wrap and reset.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_valid;
  logic [15:0] imem_rdata;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       id_valid;
  logic       id_ready;
  logic [3:0] opcode, rd, rs, imm;
  logic [7:0] id_pc;

  int checks = 0;
  int errors = 0;

  instr_fetch #(.ADDR_W(8), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready),
    .opcode(opcode), .rd(rd), .rs(rs), .imm(imm), .id_pc(id_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] rdata;
    logic        ready;
    logic        ereq;
    logic [7:0]  eaddr;
    logic        eidv;
    logic [15:0] eword;
    logic [7:0]  epc;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(logic v, logic [15:0] rdata, logic ready, logic ereq,
                              logic [7:0] eaddr, logic eidv, logic [15:0] eword, logic [7:0] epc);
    vec_t r;
    r.v = v; r.rdata = rdata; r.ready = ready; r.ereq = ereq;
    r.eaddr = eaddr; r.eidv = eidv; r.eword = eword; r.epc = epc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic v, input logic [15:0] rdata, input logic redir,
                       input logic [7:0] rpc, input logic ready);
    @(negedge clk);
    rst_n = 1'b1;
    imem_valid = v; imem_rdata = rdata; redirect = redir; redirect_pc = rpc; id_ready = ready;
    #1;
  endtask

  task automatic chk_cyc(input string name, input logic ereq, input logic [7:0] eaddr,
                         input logic eidv, input logic [15:0] eword, input logic [7:0] epc);
    chk({name, ".req"}, 32'(imem_req), 32'(ereq));
    if (ereq) chk({name, ".addr"}, 32'(imem_addr), 32'(eaddr));
    chk({name, ".idv"}, 32'(id_valid), 32'(eidv));
    if (eidv) begin
      chk({name, ".word"}, 32'({opcode, rd, rs, imm}), 32'(eword));
      chk({name, ".id_pc"}, 32'(id_pc), 32'(epc));
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, ".req0"}, 32'(imem_req), 32'd0);
    chk({name, ".addr0"}, 32'(imem_addr), 32'd0);
    chk({name, ".idv0"}, 32'(id_valid), 32'd0);
    chk({name, ".head0"}, 32'({opcode, rd, rs, imm, id_pc}), 32'd0);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    imem_valid = 1'b0; imem_rdata = 16'h0; redirect = 1'b0; redirect_pc = 8'h0; id_ready = 1'b0;
    @(negedge clk);
    #1;
    chk_zero(name);
  endtask

  initial begin
    rst_n = 1'b0;
    imem_valid = 1'b0; imem_rdata = 16'h0; redirect = 1'b0; redirect_pc = 8'h0; id_ready = 1'b0;
    #1;
    chk_zero("rst_imm");

    tbl[0]  = mk(0, 16'h0000, 1, 1, 8'h00, 0, 16'h0000, 8'h00);
    tbl[1]  = mk(1, 16'h3A51, 1, 0, 8'h00, 0, 16'h0000, 8'h00);
    tbl[2]  = mk(0, 16'h0000, 1, 1, 8'h01, 1, 16'h3A51, 8'h00);
    tbl[3]  = mk(1, 16'h1234, 1, 0, 8'h00, 0, 16'h0000, 8'h00);
    tbl[4]  = mk(0, 16'h0000, 0, 1, 8'h02, 1, 16'h1234, 8'h01);
    tbl[5]  = mk(1, 16'hBEEF, 0, 0, 8'h00, 1, 16'h1234, 8'h01);
    for (int i = 6; i <= 13; i++)
      tbl[i] = mk(0, 16'h0000, 0, 0, 8'h00, 1, 16'h1234, 8'h01);
    tbl[14] = mk(0, 16'h0000, 1, 1, 8'h03, 1, 16'h1234, 8'h01);
    tbl[15] = mk(1, 16'h5678, 1, 0, 8'h00, 1, 16'hBEEF, 8'h02);
    tbl[16] = mk(0, 16'h0000, 1, 1, 8'h04, 1, 16'h5678, 8'h03);
    tbl[17] = mk(1, 16'h0F0F, 1, 0, 8'h00, 0, 16'h0000, 8'h00);
    tbl[18] = mk(0, 16'h0000, 0, 1, 8'h05, 1, 16'h0F0F, 8'h04);

    do_reset("rst_a");
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].v, tbl[i].rdata, 1'b0, 8'h00, tbl[i].ready);
      chk_cyc($sformatf("tbl%0d", i), tbl[i].ereq, tbl[i].eaddr, tbl[i].eidv, tbl[i].eword, tbl[i].epc);
    end
    chk("tbl_fields", 32'({opcode, rd, rs, imm}), 32'h0000_0F0F);

    // Redirect while a 3-cycle response is in flight.
    do_reset("rst_b");
    drive(0, 16'h0, 0, 8'h00, 1); chk_cyc("rd_c0", 1, 8'h00, 0, 16'h0, 8'h0);
    drive(0, 16'h0, 1, 8'h40, 1); chk_cyc("rd_c1", 0, 8'h00, 0, 16'h0, 8'h0);
    drive(0, 16'h0, 0, 8'h00, 1); chk_cyc("rd_c2", 0, 8'h00, 0, 16'h0, 8'h0);
    drive(1, 16'hDEAD, 0, 8'h00, 1); chk_cyc("rd_c3", 0, 8'h00, 0, 16'h0, 8'h0);
    drive(0, 16'h0, 0, 8'h00, 1); chk_cyc("rd_c4", 1, 8'h40, 0, 16'h0, 8'h0);
    drive(1, 16'h9876, 0, 8'h00, 1); chk_cyc("rd_c5", 0, 8'h00, 0, 16'h0, 8'h0);
    drive(0, 16'h0, 0, 8'h00, 1); chk_cyc("rd_c6", 1, 8'h41, 1, 16'h9876, 8'h40);

    // PC wrap from 0xFF to 0x00.
    do_reset("rst_c");
    drive(0, 16'h0, 1, 8'hFF, 1); chk_cyc("wr_c0", 0, 8'h00, 0, 16'h0, 8'h0);
    drive(0, 16'h0, 0, 8'h00, 1); chk_cyc("wr_c1", 1, 8'hFF, 0, 16'h0, 8'h0);
    drive(1, 16'h1111, 0, 8'h00, 1); chk_cyc("wr_c2", 0, 8'h00, 0, 16'h0, 8'h0);
    drive(0, 16'h0, 0, 8'h00, 1); chk_cyc("wr_c3", 1, 8'h00, 1, 16'h1111, 8'hFF);
    drive(1, 16'h2222, 0, 8'h00, 1); chk_cyc("wr_c4", 0, 8'h00, 0, 16'h0, 8'h0);
    drive(0, 16'h0, 0, 8'h00, 1); chk_cyc("wr_c5", 1, 8'h01, 1, 16'h2222, 8'h00);

    // Redirect coinciding with a response and a pop.
    do_reset("rst_d");
    drive(0, 16'h0, 0, 8'h00, 0); chk_cyc("co_c0", 1, 8'h00, 0, 16'h0, 8'h0);
    drive(1, 16'hAAAA, 0, 8'h00, 0); chk_cyc("co_c1", 0, 8'h00, 0, 16'h0, 8'h0);
    drive(0, 16'h0, 0, 8'h00, 0); chk_cyc("co_c2", 1, 8'h01, 1, 16'hAAAA, 8'h00);
    drive(1, 16'hBBBB, 1, 8'h80, 1); chk_cyc("co_c3", 0, 8'h00, 1, 16'hAAAA, 8'h00);
    drive(0, 16'h0, 0, 8'h00, 1); chk_cyc("co_c4", 1, 8'h80, 0, 16'h0, 8'h0);
    drive(1, 16'hCCCC, 0, 8'h00, 1); chk_cyc("co_c5", 0, 8'h00, 0, 16'h0, 8'h0);
    drive(0, 16'h0, 0, 8'h00, 0); chk_cyc("co_c6", 1, 8'h81, 1, 16'hCCCC, 8'h80);

    // Asynchronous reset between request and response; the late response must be ignored.
    do_reset("rst_e");
    drive(0, 16'h0, 0, 8'h00, 0); chk_cyc("ar_c0", 1, 8'h00, 0, 16'h0, 8'h0);
    drive(0, 16'h0, 0, 8'h00, 0); chk_cyc("ar_c1", 0, 8'h00, 0, 16'h0, 8'h0);
    #2 rst_n = 1'b0;
    #1 chk_zero("ar_async");
    drive(1, 16'hBAD0, 0, 8'h00, 1); chk_cyc("ar_c2", 1, 8'h00, 0, 16'h0, 8'h0);
    drive(0, 16'h0, 0, 8'h00, 1); chk_cyc("ar_c3", 0, 8'h00, 0, 16'h0, 8'h0);
    drive(1, 16'h4321, 0, 8'h00, 1); chk_cyc("ar_c4", 0, 8'h00, 0, 16'h0, 8'h0);
    drive(0, 16'h0, 0, 8'h00, 1); chk_cyc("ar_c5", 1, 8'h01, 1, 16'h4321, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
